// File: rtl/crc_code_pkg.sv
// Shared definitions for the CRC code access sequencer: bus widths,
// parameter defaults, the sequencer FSM state encoding and a small
// saturating-increment helper used by the optional statistics counters.
package crc_code_pkg;

    localparam int ADDR_W             = 4;
    localparam int DATA_W             = 8;
    localparam int CNT_W              = 8;
    localparam int MAX_RETRY_DEF      = 2;
    localparam int TIMEOUT_CYCLES_DEF = 63;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_WAIT  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RESP     = 3'd5
    } seq_state_e;

    // Eight-bit counter step that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value != 8'hFF) begin
            result = value + 8'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/crc_seq_wait_timer.sv
// Saturating wait counter for the sequencer WAIT states. The count is
// cleared while an operation is being issued, advances once per enabled
// cycle and sticks at TIMEOUT_CYCLES; the timeout flag is registered
// alongside the count so it is high exactly when the count sits at the limit.
module crc_seq_wait_timer
    import crc_code_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             timeout_r;

    // Next count: clear wins, otherwise count up while enabled and below the limit.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (enable && (cnt_r < LIMIT)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count and timeout flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            timeout_r <= (cnt_nxt_s == LIMIT);
        end
    end

    assign wait_cnt = cnt_r;
    assign timeout  = timeout_r;

endmodule

// File: rtl/crc_code_access_sequencer.sv
// Host-side sequencer in front of a CRC-protected memory stage. Accepts one
// read or write request at a time, issues a single start pulse to the memory
// stage, waits for completion (with a bounded wait), re-issues failed reads a
// limited number of times and returns one registered response per request.
// Optional build macro: CRC_SEQ_STATS_EN adds error/failure statistics outputs.
module crc_code_access_sequencer
    import crc_code_pkg::*;
#(
    parameter int MAX_RETRY      = MAX_RETRY_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic [1:0]        rsp_retries,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_write_busy,
    input  logic              mem_read_busy,
    input  logic              mem_data_valid,
    input  logic              mem_error_detected,
    input  logic              mem_completed,
    input  logic [DATA_W-1:0] mem_data_out
`ifdef CRC_SEQ_STATS_EN
    ,
    output logic [7:0]        stat_err_cnt,
    output logic [7:0]        stat_fail_cnt
`endif
);

    localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

    seq_state_e        state_r;
    seq_state_e        state_nxt_s;

    logic              req_ready_r;
    logic              mem_write_r;
    logic              mem_read_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_data_in_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_error_r;
    logic              rsp_timeout_r;
    logic [1:0]        rsp_retries_r;
    logic [1:0]        retry_cnt_r;

    logic              accept_s;
    logic              retry_s;
    logic              wr_done_s;
    logic              rd_done_s;
    logic              to_s;
    logic              rsp_done_s;
    logic              status_live_s;

    logic [CNT_W-1:0]  wait_cnt_s;
    logic              wait_to_s;
    logic              timer_clear_s;
    logic              timer_en_s;
    logic              unused_s;

    // The read-busy status carries no information the completion strobe lacks.
    assign unused_s = mem_read_busy;

    // Memory status is trusted only after the guard cycle following the pulse.
    assign status_live_s = (wait_cnt_s != {CNT_W{1'b0}});
    assign timer_clear_s = (state_r == WR_ISSUE) || (state_r == RD_ISSUE);
    assign timer_en_s    = (state_r == WR_WAIT) || (state_r == RD_WAIT);

    crc_seq_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .wait_cnt(wait_cnt_s),
        .timeout (wait_to_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle event strobes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        retry_s     = 1'b0;
        wr_done_s   = 1'b0;
        rd_done_s   = 1'b0;
        to_s        = 1'b0;
        rsp_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = req_write ? WR_ISSUE : RD_ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_ISSUE: begin
                state_nxt_s = WR_WAIT;
            end
            WR_WAIT: begin
                if (status_live_s && !mem_write_busy) begin
                    wr_done_s   = 1'b1;
                    state_nxt_s = RESP;
                end else if (wait_to_s) begin
                    to_s        = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WR_WAIT;
                end
            end
            RD_ISSUE: begin
                state_nxt_s = RD_WAIT;
            end
            RD_WAIT: begin
                if (status_live_s && mem_completed) begin
                    if (mem_error_detected && (retry_cnt_r < RETRY_LIM)) begin
                        retry_s     = 1'b1;
                        state_nxt_s = RD_ISSUE;
                    end else begin
                        rd_done_s   = 1'b1;
                        state_nxt_s = RESP;
                    end
                end else if (wait_to_s) begin
                    to_s        = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake and start-pulse outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_r <= 1'b0;
            mem_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (state_nxt_s == IDLE);
            mem_write_r <= (state_nxt_s == WR_ISSUE);
            mem_read_r  <= (state_nxt_s == RD_ISSUE);
            rsp_valid_r <= (state_nxt_s == RESP);
        end
    end

    // Request capture and read retry counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_r    <= {ADDR_W{1'b0}};
            mem_data_in_r <= {DATA_W{1'b0}};
            retry_cnt_r   <= 2'd0;
        end else begin
            if (accept_s) begin
                mem_addr_r    <= req_addr;
                mem_data_in_r <= req_wdata;
            end
            if (accept_s || rsp_done_s) begin
                retry_cnt_r <= 2'd0;
            end else if (retry_s) begin
                retry_cnt_r <= retry_cnt_r + 2'd1;
            end
        end
    end

    // Response payload, latched on entry to RESP and held until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_data_r    <= {DATA_W{1'b0}};
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
            rsp_retries_r <= 2'd0;
        end else if (rd_done_s) begin
            rsp_data_r    <= mem_data_out;
            rsp_error_r   <= mem_error_detected || !mem_data_valid;
            rsp_timeout_r <= 1'b0;
            rsp_retries_r <= retry_cnt_r;
        end else if (wr_done_s || to_s) begin
            rsp_data_r    <= {DATA_W{1'b0}};
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= to_s;
            rsp_retries_r <= retry_cnt_r;
        end else if (rsp_done_s) begin
            rsp_data_r    <= {DATA_W{1'b0}};
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
            rsp_retries_r <= 2'd0;
        end
    end

`ifdef CRC_SEQ_STATS_EN
    logic [7:0] stat_err_cnt_r;
    logic [7:0] stat_fail_cnt_r;
    logic       rd_err_s;
    logic       fail_s;

    // Every accepted read completion flagged by the CRC stage, retried or not.
    assign rd_err_s = (state_r == RD_WAIT) && status_live_s && mem_completed
                      && mem_error_detected;
    // Every response that reports an error or a timeout.
    assign fail_s   = to_s || (rd_done_s && (mem_error_detected || !mem_data_valid));

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_err_cnt_r  <= 8'd0;
            stat_fail_cnt_r <= 8'd0;
        end else begin
            if (rd_err_s) begin
                stat_err_cnt_r <= sat_inc8(stat_err_cnt_r);
            end
            if (fail_s) begin
                stat_fail_cnt_r <= sat_inc8(stat_fail_cnt_r);
            end
        end
    end

    assign stat_err_cnt  = stat_err_cnt_r;
    assign stat_fail_cnt = stat_fail_cnt_r;
`endif

    assign req_ready   = req_ready_r;
    assign mem_write   = mem_write_r;
    assign mem_read    = mem_read_r;
    assign mem_addr    = mem_addr_r;
    assign mem_data_in = mem_data_in_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_error   = rsp_error_r;
    assign rsp_timeout = rsp_timeout_r;
    assign rsp_retries = rsp_retries_r;

endmodule
